// File: rtl/pkt_drain_if.sv
// pkt_drain_if: handshake bundle between classifier, upper FIFO read
// port, rewrite mux and the drain scheduler.
interface pkt_drain_if #(
  parameter int CNT_W = 16
);
  logic             verdict_valid;
  logic [1:0]       verdict_action;
  logic             verdict_ready;
  logic             allow_drain;
  logic             fifo_pkt_sop;
  logic             fifo_rd_valid;
  logic             fifo_rd_last;
  logic             fifo_rd_ready;
  logic             out_valid;
  logic             out_last;
  logic             out_ready;
  logic             rewrite_en;
  logic             busy;
  logic [CNT_W-1:0] fwd_cnt;
  logic [CNT_W-1:0] drop_cnt;
  logic             wdog_err;

  modport slave (
    input  verdict_valid, verdict_action,
    input  fifo_pkt_sop, fifo_rd_valid, fifo_rd_last,
    input  out_ready,
    output verdict_ready, allow_drain, fifo_rd_ready,
    output out_valid, out_last, rewrite_en, busy,
    output fwd_cnt, drop_cnt, wdog_err
  );

  modport master (
    output verdict_valid, verdict_action,
    output fifo_pkt_sop, fifo_rd_valid, fifo_rd_last,
    output out_ready,
    input  verdict_ready, allow_drain, fifo_rd_ready,
    input  out_valid, out_last, rewrite_en, busy,
    input  fwd_cnt, drop_cnt, wdog_err
  );
endinterface

// File: rtl/pkt_drain_sched.sv
// pkt_drain_sched: per-packet drain controller for the upper packet FIFO.
// Optional XFER stall watchdog enabled by defining PKT_DRAIN_WDOG_EN.
module pkt_drain_sched #(
  parameter int VQ_DEPTH    = 4,
  parameter int GAP_CYCLES  = 2,
  parameter int CNT_W       = 16,
  parameter int WDOG_CYCLES = 1024
) (
  input logic      clk,
  input logic      rst,
  pkt_drain_if.slave bus
);
  localparam int AW = $clog2(VQ_DEPTH);
  localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_ARM  = 2'd1;
  localparam logic [1:0] S_XFER = 2'd2;
  localparam logic [1:0] S_GAP  = 2'd3;

  if (VQ_DEPTH < 2 || (VQ_DEPTH & (VQ_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("VQ_DEPTH must be a power of 2 and at least 2");
  end
  if (WDOG_CYCLES < 1) begin : g_bad_wdog
    $error("WDOG_CYCLES must be at least 1");
  end

  logic [1:0]       vq_mem [VQ_DEPTH];
  logic [AW:0]      wr_ptr_q;
  logic [AW:0]      rd_ptr_q;
  logic [1:0]       state_q;
  logic [1:0]       state_d;
  logic             drop_q;
  logic             rew_q;
  logic [GW-1:0]    gap_q;
  logic [CNT_W-1:0] fwd_q;
  logic [CNT_W-1:0] drop_cnt_q;

  logic empty;
  logic full;
  logic ready_c;
  logic push;
  logic xfer;
  logic rd_ready_c;
  logic beat;
  logic done;

  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                 (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

  assign ready_c    = !full && !rst;
  assign push       = bus.verdict_valid && ready_c;
  assign xfer       = (state_q == S_XFER);
  assign rd_ready_c = xfer && (drop_q || bus.out_ready);
  assign beat       = bus.fifo_rd_valid && rd_ready_c;
  assign done       = beat && bus.fifo_rd_last;

  assign bus.verdict_ready = ready_c;
  assign bus.allow_drain   = !rst && (state_q == S_ARM);
  assign bus.fifo_rd_ready = !rst && rd_ready_c;
  assign bus.out_valid     = !rst && xfer && !drop_q && bus.fifo_rd_valid;
  assign bus.out_last      = !rst && xfer && !drop_q && bus.fifo_rd_last;
  assign bus.rewrite_en    = !rst && rew_q;
  assign bus.busy          = !rst && ((state_q != S_IDLE) || !empty);
  assign bus.fwd_cnt       = fwd_q;
  assign bus.drop_cnt      = drop_cnt_q;

  // Verdict storage; contents need no reset since pointers gate them.
  always_ff @(posedge clk) begin
    if (push) vq_mem[wr_ptr_q[AW-1:0]] <= bus.verdict_action;
  end

  // Queue pointers: push on accepted verdict, pop on packet complete.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (done) rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

  // Next-state decode for the drain FSM.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: if (!empty) state_d = S_ARM;
      S_ARM:  if (bus.fifo_pkt_sop) state_d = S_XFER;
      S_XFER: if (done) state_d = (GAP_CYCLES == 0) ? S_IDLE : S_GAP;
      S_GAP:  if (gap_q == GW'(GAP_CYCLES - 1)) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // FSM state, latched head action and inter-packet gap counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      drop_q  <= 1'b0;
      rew_q   <= 1'b0;
      gap_q   <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == S_IDLE && !empty) begin
        drop_q <= vq_mem[rd_ptr_q[AW-1:0]][0];
        rew_q  <= (vq_mem[rd_ptr_q[AW-1:0]] == 2'b10);
      end
      if (done) rew_q <= 1'b0;
      if (state_q == S_GAP) gap_q <= gap_q + 1'b1;
      else gap_q <= '0;
    end
  end

  // Saturating per-packet statistics.
  always_ff @(posedge clk) begin
    if (rst) begin
      fwd_q      <= '0;
      drop_cnt_q <= '0;
    end else if (done) begin
      if (!drop_q && fwd_q != '1) fwd_q <= fwd_q + 1'b1;
      if (drop_q && drop_cnt_q != '1) drop_cnt_q <= drop_cnt_q + 1'b1;
    end
  end

`ifdef PKT_DRAIN_WDOG_EN
  localparam int WW = $clog2(WDOG_CYCLES + 1);

  logic [WW-1:0] stall_q;
  logic [WW-1:0] stall_d;
  logic          wdog_q;

  // Stall run length; restarts on any beat and outside XFER.
  always_comb begin
    stall_d = stall_q;
    if (!xfer || beat) stall_d = '0;
    else if (stall_q != WW'(WDOG_CYCLES)) stall_d = stall_q + 1'b1;
  end

  // Sticky stall flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_q <= '0;
      wdog_q  <= 1'b0;
    end else begin
      stall_q <= stall_d;
      if (stall_d == WW'(WDOG_CYCLES)) wdog_q <= 1'b1;
    end
  end

  assign bus.wdog_err = !rst && wdog_q;
`else
  assign bus.wdog_err = 1'b0;
`endif

endmodule

// File: tb/tb_pkt_drain_sched.sv
// tb_pkt_drain_sched: directed + randomized bench for pkt_drain_sched
// with a behavioural FIFO source and a packet-level scoreboard.
`timescale 1ns/1ps
module tb_pkt_drain_sched;
  typedef struct {
    int         len;
    logic [1:0] act;
  } pkt_t;

  logic clk;
  logic rst;
  pkt_drain_if #(.CNT_W(16)) bus ();

  pkt_drain_sched #(
    .VQ_DEPTH(4), .GAP_CYCLES(2), .CNT_W(16), .WDOG_CYCLES(16)
  ) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );

  int checks = 0;
  int errors = 0;

  pkt_t fifo_q[$];
  int   exp_got[$];
  int   got_q[$];
  int   fwd_exp = 0;
  int   drop_exp = 0;
  int   pkts_done = 0;
  int   beats = 0;
  int   rem = 0;
  bit   draining = 0;
  bit   sop_phase = 0;
  bit   flush = 0;
  bit   bubbles = 0;
  int   rmode = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic add_pkt(input int len, input logic [1:0] a);
    pkt_t p;
    p.len = len;
    p.act = a;
    fifo_q.push_back(p);
    if (a[0]) drop_exp++;
    else begin
      fwd_exp++;
      exp_got.push_back(len);
    end
  endtask

  task automatic push_v(input logic [1:0] a);
    bus.verdict_valid  = 1'b1;
    bus.verdict_action = a;
    for (int i = 0; i < 500 && !bus.verdict_ready; i++) step();
    chk("push_ready", bus.verdict_ready, 1'b1);
    step();
    bus.verdict_valid = 1'b0;
  endtask

  task automatic wait_pkts(input int n, input int budget);
    for (int i = 0; i < budget && pkts_done < n; i++) step();
    chk("pkt_wait", pkts_done >= n, 1'b1);
  endtask

  task automatic wait_sop();
    bit seen;
    seen = 0;
    for (int i = 0; i < 200 && !seen; i++) begin
      step();
      if (bus.fifo_pkt_sop) seen = 1;
    end
    chk("sop_seen", seen, 1'b1);
  endtask

  task automatic cmp_got(input string tag);
    chk({tag, "_npkts"}, got_q.size(), exp_got.size());
    for (int i = 0; i < got_q.size() && i < exp_got.size(); i++)
      chk({tag, "_beats"}, got_q[i], exp_got[i]);
    got_q.delete();
    exp_got.delete();
  endtask

  // Behavioural upper FIFO: sop on allow_drain, then one packet's beats.
  initial begin : fifo_eng
    bit acc;
    bit ad;
    bit vld;
    forever begin
      @(negedge clk);
      acc = bus.fifo_rd_valid && bus.fifo_rd_ready;
      ad  = bus.allow_drain;
      vld = bus.fifo_rd_valid;
      @(posedge clk);
      #1;
      bus.fifo_pkt_sop = 1'b0;
      if (flush) begin
        draining  = 0;
        sop_phase = 0;
        fifo_q.delete();
      end else if (draining) begin
        if (sop_phase) sop_phase = 0;
        else if (acc) begin
          rem--;
          if (rem == 0) begin
            draining = 0;
            void'(fifo_q.pop_front());
            pkts_done++;
          end
        end
      end else if (ad && fifo_q.size() > 0) begin
        draining  = 1;
        sop_phase = 1;
        rem       = fifo_q[0].len;
        bus.fifo_pkt_sop = 1'b1;
      end
      if (draining && !sop_phase) begin
        if (!(vld && !acc))
          bus.fifo_rd_valid = bubbles ? ($urandom_range(0, 3) != 0) : 1'b1;
        bus.fifo_rd_last = (rem == 1);
      end else begin
        bus.fifo_rd_valid = 1'b0;
        bus.fifo_rd_last  = 1'b0;
      end
    end
  end

  // Downstream ready pattern generator.
  initial begin : rdy_gen
    forever begin
      @(posedge clk);
      #1;
      if (rmode == 1) bus.out_ready = ($urandom_range(0, 1) == 1);
      else if (rmode == 2) bus.out_ready = !bus.out_ready;
    end
  end

  // Per-cycle gating rules and output packet reassembly.
  initial begin : mon
    logic [1:0] a;
    bit fwd;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (draining && !sop_phase && fifo_q.size() > 0) begin
          a   = fifo_q[0].act;
          fwd = !a[0];
          chk("pt_valid", bus.out_valid, fwd ? bus.fifo_rd_valid : 1'b0);
          chk("pt_last", bus.out_last, fwd ? bus.fifo_rd_last : 1'b0);
          chk("pt_ready", bus.fifo_rd_ready, fwd ? bus.out_ready : 1'b1);
          chk("rw_level", bus.rewrite_en, a == 2'b10);
          chk("ad_low", bus.allow_drain, 1'b0);
        end else begin
          chk("idle_ov", bus.out_valid, 1'b0);
          chk("idle_rr", bus.fifo_rd_ready, 1'b0);
        end
        if (bus.out_valid && bus.out_ready) begin
          beats++;
          if (bus.out_last) begin
            got_q.push_back(beats);
            beats = 0;
          end
        end
      end
    end
  end

  initial begin : guard
    #2000000;
    $display("FAIL global_timeout: observed running expected finished");
    $fatal(1, "timeout");
  end

  initial begin : main
    int base;
    int n;
    logic [1:0] acts[5];
    int lens[5];
    rst = 1'b1;
    bus.verdict_valid  = 1'b0;
    bus.verdict_action = 2'b00;
    bus.out_ready      = 1'b0;
    bus.fifo_pkt_sop   = 1'b0;
    bus.fifo_rd_valid  = 1'b0;
    bus.fifo_rd_last   = 1'b0;
    step();
    step();
    chk("rst_ad", bus.allow_drain, 1'b0);
    chk("rst_busy", bus.busy, 1'b0);
    chk("rst_vr", bus.verdict_ready, 1'b0);
    chk("rst_fwd", bus.fwd_cnt, 0);
    chk("rst_drop", bus.drop_cnt, 0);
    rst = 1'b0;
    step();
    chk("post_rst_vr", bus.verdict_ready, 1'b1);
    chk("post_rst_wdog", bus.wdog_err, 1'b0);

    // 1: single forward packet, timing of allow_drain and gap
    bus.out_ready = 1'b1;
    base = pkts_done;
    add_pkt(4, 2'b00);
    push_v(2'b00);
    chk("t1_ad_pre", bus.allow_drain, 1'b0);
    chk("t1_busy", bus.busy, 1'b1);
    step();
    chk("t1_ad_rise", bus.allow_drain, 1'b1);
    wait_sop();
    chk("t1_ad_sop", bus.allow_drain, 1'b1);
    step();
    chk("t1_ad_fall", bus.allow_drain, 1'b0);
    wait_pkts(base + 1, 100);
    chk("t1_fwd", bus.fwd_cnt, 1);
    chk("t1_gap1", bus.busy, 1'b1);
    step();
    chk("t1_gap2", bus.busy, 1'b1);
    chk("t1_gap_ad", bus.allow_drain, 1'b0);
    step();
    chk("t1_idle", bus.busy, 1'b0);
    cmp_got("t1");

    // 2: drop with downstream stalled; next packet untouched
    bus.out_ready = 1'b0;
    base = pkts_done;
    add_pkt(6, 2'b01);
    add_pkt(3, 2'b00);
    push_v(2'b01);
    wait_pkts(base + 1, 100);
    chk("t2_drop", bus.drop_cnt, 1);
    step();
    step();
    step();
    chk("t2_left", fifo_q.size(), 1);
    chk("t2_notdrain", draining, 1'b0);
    bus.out_ready = 1'b1;
    push_v(2'b00);
    wait_pkts(base + 2, 100);
    cmp_got("t2");
    chk("t2_fwd", bus.fwd_cnt, 2);

    // 3: five verdicts back-to-back against a 4-entry queue
    for (int i = 0; i < 5; i++) begin
      acts[i] = 2'($urandom_range(0, 3));
      lens[i] = i + 2;
      add_pkt(lens[i], acts[i]);
    end
    repeat (4) step();
    base = pkts_done;
    bus.verdict_valid  = 1'b1;
    bus.verdict_action = acts[0];
    for (int k = 1; k < 5; k++) begin
      step();
      bus.verdict_action = acts[k];
    end
    n = 0;
    while (pkts_done == base && n < 200) begin
      chk("t3_held", bus.verdict_ready, 1'b0);
      step();
      n++;
    end
    chk("t3_rdy_ret", bus.verdict_ready, 1'b1);
    step();
    bus.verdict_valid = 1'b0;
    wait_pkts(base + 5, 500);
    cmp_got("t3");
    chk("t3_fwd", bus.fwd_cnt, fwd_exp);
    chk("t3_drop", bus.drop_cnt, drop_exp);

    // 4: rewrite packet with out_ready toggling 1,0,1,0
    repeat (3) step();
    base = pkts_done;
    add_pkt(3, 2'b10);
    bus.out_ready = 1'b1;
    rmode = 2;
    push_v(2'b10);
    step();
    chk("t4_rw_arm", bus.rewrite_en, 1'b1);
    wait_pkts(base + 1, 100);
    chk("t4_rw_clr", bus.rewrite_en, 1'b0);
    rmode = 0;
    cmp_got("t4");

    // 5: armed with empty FIFO, then reset mid-transfer
    repeat (3) step();
    bus.out_ready = 1'b1;
    push_v(2'b00);
    step();
    for (int i = 0; i < 20; i++) begin
      step();
      chk("t5_arm_hold", bus.allow_drain, 1'b1);
    end
    add_pkt(5, 2'b00);
    wait_sop();
    step();
    step();
    chk("t5_in_xfer", bus.fifo_rd_ready, 1'b1);
    rst   = 1'b1;
    flush = 1'b1;
    step();
    chk("t5_rst_ad", bus.allow_drain, 1'b0);
    chk("t5_rst_rr", bus.fifo_rd_ready, 1'b0);
    chk("t5_rst_ov", bus.out_valid, 1'b0);
    chk("t5_rst_ol", bus.out_last, 1'b0);
    chk("t5_rst_busy", bus.busy, 1'b0);
    chk("t5_rst_fwd", bus.fwd_cnt, 0);
    chk("t5_rst_drop", bus.drop_cnt, 0);
    rst   = 1'b0;
    flush = 1'b0;
    beats = 0;
    got_q.delete();
    exp_got.delete();
    fwd_exp  = 0;
    drop_exp = 0;
    step();
    chk("t5_after_busy", bus.busy, 1'b0);
    chk("t5_after_vr", bus.verdict_ready, 1'b1);

    // Randomized traffic: lengths, actions, bubbles, backpressure
    bubbles = 1;
    rmode   = 1;
    base    = pkts_done;
    for (int i = 0; i < 30; i++) begin
      lens[0] = $urandom_range(1, 8);
      acts[0] = 2'($urandom_range(0, 3));
      add_pkt(lens[0], acts[0]);
      push_v(acts[0]);
    end
    wait_pkts(base + 30, 5000);
    cmp_got("rnd");
    chk("rnd_fwd", bus.fwd_cnt, fwd_exp);
    chk("rnd_drop", bus.drop_cnt, drop_exp);
    rmode   = 0;
    bubbles = 0;

`ifdef PKT_DRAIN_WDOG_EN
    // 6: stalled forward packet trips the watchdog
    bus.out_ready = 1'b0;
    base = pkts_done;
    add_pkt(2, 2'b00);
    push_v(2'b00);
    wait_sop();
    step();
    repeat (15) step();
    chk("t6_wdog_pre", bus.wdog_err, 1'b0);
    step();
    chk("t6_wdog_set", bus.wdog_err, 1'b1);
    bus.out_ready = 1'b1;
    wait_pkts(base + 1, 100);
    step();
    chk("t6_wdog_sticky", bus.wdog_err, 1'b1);
    cmp_got("t6");
`else
    chk("wdog_off", bus.wdog_err, 1'b0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
